// File: rtl/fp_addsub_align.sv
// fp_addsub_align: operand preparation for the serial binary32 add/sub core.
// Unpacks A and B, applies op to B's sign, classifies NaN/inf, orders the
// operands by magnitude and right-aligns the smaller significand one bit per
// clock with sticky collection.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the previous result
// LOAD  | classify, compare magnitudes, swap, compute the shift count
// ALIGN | shift the smaller significand right one bit per clock
// DONE  | ready pulse; aligned operands are valid
module fp_addsub_align #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        busy,
  output logic        ready,
  output logic [7:0]  exp_o,
  output logic [26:0] man_l_o,
  output logic [26:0] man_s_o,
  output logic        sign_l_o,
  output logic        sign_s_o,
  output logic        eff_sub_o,
  output logic        swapped_o,
  output logic        special_valid_o,
  output logic [31:0] special_o
);

  localparam int         CW          = $clog2(MAX_SHIFT + 1);
  localparam logic [7:0] MAX_SHIFT_E = 8'(MAX_SHIFT);
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ALIGN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_op;
  logic [CW-1:0] r_cnt;

  logic          w_sa;
  logic          w_sb;
  logic [7:0]    w_ea;
  logic [7:0]    w_eb;
  logic [22:0]   w_fa;
  logic [22:0]   w_fb;
  logic          w_nan_a;
  logic          w_nan_b;
  logic          w_inf_a;
  logic          w_inf_b;
  logic          w_swap;
  logic [7:0]    w_el;
  logic [7:0]    w_es;
  logic [22:0]   w_fl;
  logic [22:0]   w_fs;
  logic          w_sl;
  logic          w_ss;
  logic [7:0]    w_el_adj;
  logic [7:0]    w_es_adj;
  logic [26:0]   w_man_l;
  logic [26:0]   w_man_s;
  logic [7:0]    w_diff;
  logic [CW-1:0] w_shift;
  logic          w_special;
  logic [31:0]   w_special_val;
  logic [26:0]   w_shifted;

  // Unpack the captured operands; op=0 means subtract, which flips B's sign.
  assign w_sa = r_a[31];
  assign w_sb = r_b[31] ^ ~r_op;
  assign w_ea = r_a[30:23];
  assign w_eb = r_b[30:23];
  assign w_fa = r_a[22:0];
  assign w_fb = r_b[22:0];

  assign w_nan_a = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_nan_b = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_inf_a = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_inf_b = (w_eb == 8'hFF) && (w_fb == 23'd0);

  // {exp,frac} orders magnitudes directly; ties keep A as the larger operand.
  assign w_swap = (r_b[30:0] > r_a[30:0]);
  assign w_el   = w_swap ? w_eb : w_ea;
  assign w_es   = w_swap ? w_ea : w_eb;
  assign w_fl   = w_swap ? w_fb : w_fa;
  assign w_fs   = w_swap ? w_fa : w_fb;
  assign w_sl   = w_swap ? w_sb : w_sa;
  assign w_ss   = w_swap ? w_sa : w_sb;

  // Denormals and zero share the scale of exponent 1 with no hidden bit.
  assign w_el_adj = (w_el == 8'd0) ? 8'd1 : w_el;
  assign w_es_adj = (w_es == 8'd0) ? 8'd1 : w_es;
  assign w_man_l  = {(w_el != 8'd0), w_fl, 3'b000};
  assign w_man_s  = {(w_es != 8'd0), w_fs, 3'b000};

  // Beyond MAX_SHIFT every significand bit has already folded into sticky.
  assign w_diff  = w_el_adj - w_es_adj;
  assign w_shift = (w_diff > MAX_SHIFT_E) ? CW'(MAX_SHIFT) : w_diff[CW-1:0];

  // One alignment step: logical right shift, bit 0 accumulates lost bits.
  assign w_shifted = {1'b0, man_s_o[26:2], man_s_o[1] | man_s_o[0]};

  // Special-value priority: NaN, inf-inf, then a lone (or same-signed) inf.
  always_comb begin
    w_special     = 1'b0;
    w_special_val = 32'd0;
    if (w_nan_a || w_nan_b) begin
      w_special     = 1'b1;
      w_special_val = QNAN;
    end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
      w_special     = 1'b1;
      w_special_val = QNAN;
    end else if (w_inf_a) begin
      w_special     = 1'b1;
      w_special_val = {w_sa, 8'hFF, 23'd0};
    end else if (w_inf_b) begin
      w_special     = 1'b1;
      w_special_val = {w_sb, 8'hFF, 23'd0};
    end
  end

  // Sequencer with registered outputs; results hold from DONE until next start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_a             <= 32'd0;
      r_b             <= 32'd0;
      r_op            <= 1'b0;
      r_cnt           <= '0;
      busy            <= 1'b0;
      ready           <= 1'b0;
      exp_o           <= 8'd0;
      man_l_o         <= 27'd0;
      man_s_o         <= 27'd0;
      sign_l_o        <= 1'b0;
      sign_s_o        <= 1'b0;
      eff_sub_o       <= 1'b0;
      swapped_o       <= 1'b0;
      special_valid_o <= 1'b0;
      special_o       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            r_a     <= data_a;
            r_b     <= data_b;
            r_op    <= op;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          exp_o           <= w_el_adj;
          man_l_o         <= w_man_l;
          man_s_o         <= w_man_s;
          sign_l_o        <= w_sl;
          sign_s_o        <= w_ss;
          eff_sub_o       <= w_sl ^ w_ss;
          swapped_o       <= w_swap;
          special_valid_o <= w_special;
          special_o       <= w_special_val;
          r_cnt           <= w_shift;
          if (w_special || (w_shift == '0)) begin
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          man_s_o <= w_shifted;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          ready   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          ready   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_align.sv
// Scoreboard bench for fp_addsub_align: the driver pushes expected results
// from an arithmetic reference model, the monitor pops on every ready pulse.
module tb_fp_addsub_align;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        busy;
  logic        ready;
  logic [7:0]  exp_o;
  logic [26:0] man_l_o;
  logic [26:0] man_s_o;
  logic        sign_l_o;
  logic        sign_s_o;
  logic        eff_sub_o;
  logic        swapped_o;
  logic        special_valid_o;
  logic [31:0] special_o;

  fp_addsub_align #(.MAX_SHIFT(26)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .busy(busy), .ready(ready),
    .exp_o(exp_o), .man_l_o(man_l_o), .man_s_o(man_s_o),
    .sign_l_o(sign_l_o), .sign_s_o(sign_s_o), .eff_sub_o(eff_sub_o),
    .swapped_o(swapped_o), .special_valid_o(special_valid_o),
    .special_o(special_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          k;
    int          lat;
    logic [7:0]  e;
    logic [26:0] ml;
    logic [26:0] ms;
    logic        sl;
    logic        ss;
    logic        es;
    logic        sw;
    logic        sv;
    logic [31:0] so;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   ready_cnt = 0;
  int   busy_cnt = 0;
  logic prev_ready = 1'b0;
  exp_t me;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference: value-level IEEE rules with integer arithmetic for the shift.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic o, input int k);
    exp_t   r;
    logic   sa, sbe;
    int     ea, eb, el, es, d;
    longint fa, fb, fl, fs, ml, ms, lost;
    bit     na, nb, ia, ib, sw;
    sa  = a[31];
    sbe = b[31] ^ ~o;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = longint'(a[22:0]);
    fb  = longint'(b[22:0]);
    na  = (ea == 255) && (fa != 0);
    nb  = (eb == 255) && (fb != 0);
    ia  = (ea == 255) && (fa == 0);
    ib  = (eb == 255) && (fb == 0);
    r.k  = k;
    r.sv = 1'b0;
    r.so = 32'd0;
    if (na || nb) begin
      r.sv = 1'b1; r.so = 32'h7FC00000;
    end else if (ia && ib && (sa != sbe)) begin
      r.sv = 1'b1; r.so = 32'h7FC00000;
    end else if (ia) begin
      r.sv = 1'b1; r.so = {sa, 8'hFF, 23'd0};
    end else if (ib) begin
      r.sv = 1'b1; r.so = {sbe, 8'hFF, 23'd0};
    end
    // Magnitude: exponent dominates, fraction breaks ties; equal keeps A.
    sw = (eb > ea) || ((eb == ea) && (fb > fa));
    el = sw ? eb : ea;
    es = sw ? ea : eb;
    fl = sw ? fb : fa;
    fs = sw ? fa : fb;
    ml = ((el != 0) ? (64'd1 << 26) : 64'd0) + fl * 8;
    ms = ((es != 0) ? (64'd1 << 26) : 64'd0) + fs * 8;
    if (el == 0) el = 1;
    if (es == 0) es = 1;
    d = el - es;
    if (d > 26) d = 26;
    lost = ms % (64'd1 << d);
    r.ms  = 27'((ms >> d) | ((lost != 0) ? 64'd1 : 64'd0));
    r.ml  = 27'(ml);
    r.e   = 8'(el);
    r.sl  = sw ? sbe : sa;
    r.ss  = sw ? sa : sbe;
    r.es  = r.sl ^ r.ss;
    r.sw  = sw;
    r.lat = r.sv ? 0 : d;
    return r;
  endfunction

  // Monitor: pops one expectation per ready pulse and checks it.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      busy_cnt   = 0;
      prev_ready = 1'b0;
    end else begin
      if (prev_ready) chk("ready_pulse_width", {31'd0, ready}, 32'd0);
      if (busy) busy_cnt++;
      if (ready) begin
        ready_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          chk("ready_cycle", cyc, me.k + 1 + me.lat);
          chk("busy_cycles", busy_cnt, me.lat + 1);
          chk("special_valid", {31'd0, special_valid_o}, {31'd0, me.sv});
          if (me.sv) begin
            chk("special_o", special_o, me.so);
          end else begin
            chk("exp_o", {24'd0, exp_o}, {24'd0, me.e});
            chk("man_l_o", {5'd0, man_l_o}, {5'd0, me.ml});
            chk("man_s_o", {5'd0, man_s_o}, {5'd0, me.ms});
            chk("signs", {28'd0, sign_l_o, sign_s_o, eff_sub_o, swapped_o},
                {28'd0, me.sl, me.ss, me.es, me.sw});
          end
        end
        busy_cnt = 0;
      end
      prev_ready = ready;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o);
    exp_t e;
    @(negedge clock);
    data_a = a;
    data_b = b;
    op     = o;
    start  = 1'b1;
    e = model(a, b, o, cyc + 1);
    sb.push_back(e);
    @(negedge clock);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    op     = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic o);
    issue(a, b, o);
    wait_done();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          c;
    v = $urandom;
    c = $urandom_range(0, 11);
    case (c)
      0: v[30:0] = 31'd0;
      1: v[30:23] = 8'd0;
      2: v[30:0] = {8'hFF, 23'd0};
      3: begin v[30:23] = 8'hFF; if (v[22:0] == 23'd0) v[0] = 1'b1; end
      default: if (v[30:23] == 8'hFF || v[30:23] == 8'd0) v[30:23] = 8'h80;
    endcase
    return v;
  endfunction

  initial begin
    int          rc;
    logic [31:0] a, b;
    logic [7:0]  e2;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 1'b1;
    data_a = 32'd0;
    data_b = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_busy_ready", {30'd0, busy, ready}, 32'd0);
    chk("reset_exp_sv", {23'd0, exp_o, special_valid_o}, 32'd0);
    chk("reset_man_l", {5'd0, man_l_o}, 32'd0);
    chk("reset_man_s", {5'd0, man_s_o}, 32'd0);
    chk("reset_special_o", special_o, 32'd0);
    reset = 1'b1;

    run(32'h3F800000, 32'h3F800000, 1'b1);
    chk("tp1_man_l", {5'd0, man_l_o}, 32'h4000000);
    chk("tp1_man_s", {5'd0, man_s_o}, 32'h4000000);
    run(32'h3F800000, 32'h3F000000, 1'b1);
    chk("tp2_man_s", {5'd0, man_s_o}, 32'h2000000);
    run(32'h3F000000, 32'hC0000000, 1'b1);
    chk("tp3_flags", {27'd0, exp_o == 8'h80, swapped_o, sign_l_o, sign_s_o, eff_sub_o},
        {27'd0, 5'b11101});
    chk("tp3_man_s", {5'd0, man_s_o}, 32'h1000000);
    run(32'h4B800000, 32'h3F800001, 1'b1);
    chk("tp4_sticky", {5'd0, man_s_o}, 32'h0000005);
    run(32'h7F000000, 32'h3F800000, 1'b1);
    chk("tp5_saturate", {5'd0, man_s_o}, 32'h0000001);
    run(32'h7F800000, 32'h7F800000, 1'b0);
    chk("tp6_inf_minus_inf", special_o, 32'h7FC00000);
    run(32'h7FC00001, 32'h12345678, 1'b1);
    chk("tp6_nan", special_o, 32'h7FC00000);
    run(32'hFF800000, 32'h3F800000, 1'b0);
    run(32'h00000000, 32'h80000000, 1'b0);
    run(32'h00400000, 32'h00000001, 1'b1);

    // start pulsed during ALIGN must be dropped
    rc = ready_cnt;
    issue(32'h4B800000, 32'h3F800001, 1'b1);
    repeat (4) @(negedge clock);
    data_a = 32'h40000000;
    data_b = 32'h40000000;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    wait_done();
    repeat (6) @(negedge clock);
    chk("ignored_start_one_ready", ready_cnt, rc + 1);

    // reset mid-ALIGN aborts without a ready
    issue(32'h4B800000, 32'h3F800001, 1'b1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_busy_ready", {30'd0, busy, ready}, 32'd0);
    chk("abort_man_s", {5'd0, man_s_o}, 32'd0);
    chk("abort_man_l_exp", {man_l_o, exp_o[4:0]}, 32'd0);
    rc = ready_cnt;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("abort_no_ready", ready_cnt, rc);
    run(32'h3F800000, 32'h3F000000, 1'b1);

    for (int i = 0; i < 200; i++) begin
      a = rand_fp();
      b = rand_fp();
      if ($urandom_range(0, 1) == 1 && a[30:23] != 8'hFF) begin
        e2 = a[30:23] - 8'($urandom_range(0, 5));
        if (e2 != 8'hFF) b[30:23] = e2;
      end
      run(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
